// File: rtl/freq_generator_if.sv
// Request/status bundle for freq_generator.
// The frequency request goes in; the tone and divider status come out.
interface freq_generator_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] freq_in;
    logic             load;
    logic             signalOut;
    logic             busy;
    logic [WIDTH-1:0] half_period;
    logic             clamped;

    modport master (
        output freq_in, load,
        input  signalOut, busy, half_period, clamped
    );

    modport slave (
        input  freq_in, load,
        output signalOut, busy, half_period, clamped
    );
endinterface

// File: rtl/freq_generator.sv
// Programmable 50%-duty square-wave source. A restoring divider turns the requested
// frequency into a half-period of CLK_HZ / (2*f) clock cycles.
//
// state | meaning
// IDLE  | no tone, signalOut held low
// DIV   | restoring divider running, one quotient bit per cycle
// RUN   | tone active
module freq_generator #(
    parameter int unsigned CLK_HZ = 50_000_000,
    parameter int          WIDTH  = 32
) (
    input  logic            clock,
    input  logic            reset,
    freq_generator_if.slave bus
);
    localparam int               CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] DIVIDEND = WIDTH'(CLK_HZ);
    localparam logic [CW-1:0]    LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             tone_q, tone_d;
    logic             sig_q, sig_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] hp_q, hp_d;
    logic             clamp_q, clamp_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH:0]   dsr_q, dsr_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [CW-1:0]    bit_q, bit_d;

    logic [WIDTH+1:0] rem_sh;
    logic [WIDTH:0]   diff;
    logic             qbit;
    logic [WIDTH-1:0] quot;
    logic             accept;
    logic             commit;
    logic             zero_req;
    logic [WIDTH-1:0] hp_new;
    logic             clamp_new;
    logic [WIDTH-1:0] reload_hp;

    // Divider step: dvd_q shifts the dividend out at the top and the quotient in at the bottom.
    always_comb begin
        rem_sh = {rem_q, dvd_q[WIDTH-1]};
        diff   = rem_sh[WIDTH:0] - dsr_q;
        qbit   = (rem_sh >= {1'b0, dsr_q});
        quot   = {dvd_q[WIDTH-2:0], qbit};
    end

    always_comb begin
        accept    = bus.load && (state_q != DIV);
        commit    = (state_q == DIV) && (bit_q == '0);
        zero_req  = (dsr_q == '0);
        clamp_new = !zero_req && (quot == '0);
        if (zero_req) begin
            hp_new = '0;
        end else if (quot == '0) begin
            hp_new = WIDTH'(1);
        end else begin
            hp_new = quot;
        end
        reload_hp = commit ? hp_new : hp_q;
    end

    always_comb begin
        state_d = state_q;
        tone_d  = tone_q;
        sig_d   = sig_q;
        cnt_d   = cnt_q;
        hp_d    = hp_q;
        clamp_d = clamp_q;
        rem_d   = rem_q;
        dsr_d   = dsr_q;
        dvd_d   = dvd_q;
        bit_d   = bit_q;

        // An old tone keeps running through DIV; a reload coinciding with commit takes the new value.
        if (tone_q) begin
            if (cnt_q == '0) begin
                sig_d = ~sig_q;
                cnt_d = reload_hp - WIDTH'(1);
            end else begin
                cnt_d = cnt_q - WIDTH'(1);
            end
        end

        case (state_q)
            IDLE, RUN: begin
                if (accept) begin
                    state_d = DIV;
                    dsr_d   = {bus.freq_in, 1'b0};
                    dvd_d   = DIVIDEND;
                    rem_d   = '0;
                    bit_d   = LAST_BIT;
                end
            end
            DIV: begin
                rem_d = qbit ? diff : rem_sh[WIDTH:0];
                dvd_d = quot;
                bit_d = bit_q - CW'(1);
                if (commit) begin
                    hp_d    = hp_new;
                    clamp_d = clamp_new;
                    if (zero_req) begin
                        state_d = IDLE;
                        tone_d  = 1'b0;
                        sig_d   = 1'b0;
                        cnt_d   = '0;
                    end else begin
                        state_d = RUN;
                        tone_d  = 1'b1;
                        if (!tone_q) begin
                            cnt_d = hp_new - WIDTH'(1);
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tone_d  = 1'b0;
                sig_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            tone_q  <= 1'b0;
            sig_q   <= 1'b0;
            cnt_q   <= '0;
            hp_q    <= '0;
            clamp_q <= 1'b0;
            rem_q   <= '0;
            dsr_q   <= '0;
            dvd_q   <= '0;
            bit_q   <= '0;
        end else begin
            state_q <= state_d;
            tone_q  <= tone_d;
            sig_q   <= sig_d;
            cnt_q   <= cnt_d;
            hp_q    <= hp_d;
            clamp_q <= clamp_d;
            rem_q   <= rem_d;
            dsr_q   <= dsr_d;
            dvd_q   <= dvd_d;
            bit_q   <= bit_d;
        end
    end

    assign bus.signalOut   = sig_q;
    assign bus.busy        = (state_q == DIV);
    assign bus.half_period = hp_q;
    assign bus.clamped     = clamp_q;
endmodule

// File: tb/tb_freq_generator.sv
// Scoreboard bench for freq_generator: expected commits and expected tone edges are
// queued when stimulus is driven and popped as the DUT produces them.
module tb_freq_generator;
    localparam int W = 32;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] hp;
        logic         cl;
    } res_t;

    typedef struct {
        int   t;
        logic v;
    } edge_t;

    res_t  res_q[$];
    edge_t edge_q[$];

    freq_generator_if #(.WIDTH(W)) bus();
    freq_generator_if #(.WIDTH(W)) bus_big();

    freq_generator #(.CLK_HZ(1000), .WIDTH(W)) u_dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    freq_generator #(.CLK_HZ(50_000_000), .WIDTH(W)) u_big (
        .clock (clock),
        .reset (reset),
        .bus   (bus_big)
    );

    function automatic res_t model(input logic [W-1:0] f, input longint unsigned hz);
        res_t r;
        longint unsigned fl;
        longint unsigned q;
        fl = {32'b0, f};
        if (fl == 0) begin
            r.hp = '0;
            r.cl = 1'b0;
        end else begin
            q = hz / (2 * fl);
            if (q == 0) begin
                r.hp = 32'd1;
                r.cl = 1'b1;
            end else begin
                r.hp = 32'(q);
                r.cl = 1'b0;
            end
        end
        return r;
    endfunction

    task automatic apply_reset();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic do_load(input logic [W-1:0] f, input bit push, output int acc);
        @(negedge clock);
        bus.freq_in = f;
        bus.load    = 1'b1;
        @(posedge clock);
        #1;
        acc      = cyc;
        bus.load = 1'b0;
        if (push) res_q.push_back(model(f, 64'd1000));
    endtask

    task automatic wait_commit(input string name, input int exp_n, output int c);
        int   n;
        res_t e;
        n = 0;
        @(negedge clock);
        while (bus.busy === 1'b1 && n < 100) begin
            n++;
            @(negedge clock);
        end
        c = cyc;
        checks++;
        if (n != exp_n) begin
            errors++;
            $display("FAIL %s busy_cycles got %0d expected %0d", name, n, exp_n);
        end
        if (res_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s no queued result got hp %0d", name, bus.half_period);
        end else begin
            e = res_q.pop_front();
            checks++;
            if (bus.half_period !== e.hp) begin
                errors++;
                $display("FAIL %s half_period got %0d expected %0d", name, bus.half_period, e.hp);
            end
            checks++;
            if (bus.clamped !== e.cl) begin
                errors++;
                $display("FAIL %s clamped got %b expected %b", name, bus.clamped, e.cl);
            end
        end
    endtask

    task automatic check_edges(input string name, input int budget);
        logic  prev;
        int    t;
        edge_t e;
        prev = bus.signalOut;
        t    = 0;
        while (edge_q.size() > 0 && t < budget) begin
            @(negedge clock);
            t++;
            if (bus.signalOut !== prev) begin
                prev = bus.signalOut;
                e    = edge_q.pop_front();
                checks++;
                if (cyc != e.t || prev !== e.v) begin
                    errors++;
                    $display("FAIL %s edge got cycle %0d value %b expected cycle %0d value %b",
                             name, cyc, prev, e.t, e.v);
                end
            end
        end
        if (edge_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL %s timeout got %0d edges missing expected 0", name, edge_q.size());
            edge_q.delete();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clock);
        checks++;
        if (bus.signalOut !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_sig_busy got %b/%b expected 0/0", bus.signalOut, bus.busy);
        end
        checks++;
        if (bus.half_period !== '0 || bus.clamped !== 1'b0) begin
            errors++;
            $display("FAIL reset_hp_clamp got %0d/%b expected 0/0", bus.half_period, bus.clamped);
        end
        checks++;
        if (bus_big.busy !== 1'b0 || bus_big.half_period !== '0) begin
            errors++;
            $display("FAIL reset_big got %b/%0d expected 0/0", bus_big.busy, bus_big.half_period);
        end
    endtask

    task automatic test_basic();
        int a, c;
        apply_reset();
        do_load(32'd100, 1'b1, a);
        wait_commit("basic", 32, c);
        for (int i = 1; i <= 20; i++) edge_q.push_back('{c + 5 * i, (i % 2) == 1});
        check_edges("basic_edges", 120);
    endtask

    task automatic test_slow_and_zero();
        int a, c, c2, highs;
        apply_reset();
        do_load(32'd3, 1'b1, a);
        wait_commit("slow", 32, c);
        for (int i = 1; i <= 4; i++) edge_q.push_back('{c + 166 * i, (i % 2) == 1});
        check_edges("slow_edges", 700);
        // Tone rises again at c+830 and stays high across the whole divide below.
        repeat (170) @(negedge clock);
        do_load(32'd0, 1'b1, a);
        wait_commit("zero", 32, c2);
        highs = 0;
        for (int i = 0; i < 400; i++) begin
            if (bus.signalOut !== 1'b0) highs++;
            @(negedge clock);
        end
        checks++;
        if (highs != 0) begin
            errors++;
            $display("FAIL zero_silent got %0d high samples expected 0", highs);
        end
    endtask

    task automatic test_clamp();
        int   a, c, toggles;
        logic prev;
        apply_reset();
        do_load(32'd1000, 1'b1, a);
        wait_commit("clamp", 32, c);
        for (int i = 1; i <= 6; i++) edge_q.push_back('{c + i, (i % 2) == 1});
        check_edges("clamp_edges", 20);
        do_load(32'd500, 1'b1, a);
        wait_commit("exact_one", 32, c);
        toggles = 0;
        prev    = bus.signalOut;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (bus.signalOut !== prev) toggles++;
            prev = bus.signalOut;
        end
        checks++;
        if (toggles != 10) begin
            errors++;
            $display("FAIL exact_one_toggles got %0d expected 10", toggles);
        end
    endtask

    task automatic test_back_to_back();
        int   a, b, c1, c2, k, e0;
        logic v;
        apply_reset();
        do_load(32'd100, 1'b1, a);
        wait_commit("b2b_first", 32, c1);
        for (int i = 1; i <= 6; i++) edge_q.push_back('{c1 + 5 * i, (i % 2) == 1});
        fork
            check_edges("b2b_edges", 120);
            begin
                do_load(32'd50, 1'b1, a);
                k = 7;
                while (c1 + 5 * k < a + 32) begin
                    edge_q.push_back('{c1 + 5 * k, (k % 2) == 1});
                    k++;
                end
                e0 = c1 + 5 * k;
                v  = ((k % 2) == 1);
                for (int i = 0; i < 4; i++) edge_q.push_back('{e0 + 10 * i, (i % 2 == 0) ? v : ~v});
                repeat (2) @(negedge clock);
                do_load(32'd10, 1'b0, b);
                wait_commit("b2b_second", 32 - (b - a), c2);
            end
        join
    endtask

    task automatic test_reset_mid_div();
        int a, c, bad;
        apply_reset();
        do_load(32'd100, 1'b1, a);
        wait_commit("abort_setup", 32, c);
        repeat (12) @(negedge clock);
        do_load(32'd50, 1'b0, a);
        repeat (11) @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.signalOut !== 1'b0) begin
            errors++;
            $display("FAIL abort_async_busy_sig got %b/%b expected 0/0", bus.busy, bus.signalOut);
        end
        checks++;
        if (bus.half_period !== '0 || bus.clamped !== 1'b0) begin
            errors++;
            $display("FAIL abort_async_hp_clamp got %0d/%b expected 0/0", bus.half_period, bus.clamped);
        end
        repeat (2) @(negedge clock);
        reset = 1'b0;
        bad   = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            if (bus.busy !== 1'b0 || bus.signalOut !== 1'b0 || bus.half_period !== '0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL abort_no_commit got %0d bad samples expected 0", bad);
        end
    endtask

    task automatic test_wide();
        int   n;
        res_t e;
        apply_reset();
        @(negedge clock);
        bus_big.freq_in = 32'hFFFF_FFFF;
        bus_big.load    = 1'b1;
        res_q.push_back(model(32'hFFFF_FFFF, 64'd50_000_000));
        @(posedge clock);
        #1;
        bus_big.load = 1'b0;
        n = 0;
        @(negedge clock);
        while (bus_big.busy === 1'b1 && n < 100) begin
            n++;
            @(negedge clock);
        end
        checks++;
        if (n != 32) begin
            errors++;
            $display("FAIL wide_busy got %0d expected 32", n);
        end
        e = res_q.pop_front();
        checks++;
        if (bus_big.half_period !== e.hp || bus_big.clamped !== e.cl) begin
            errors++;
            $display("FAIL wide_result got %0d/%b expected %0d/%b",
                     bus_big.half_period, bus_big.clamped, e.hp, e.cl);
        end
    endtask

    initial begin
        bus.freq_in     = '0;
        bus.load        = 1'b0;
        bus_big.freq_in = '0;
        bus_big.load    = 1'b0;
        test_reset();
        test_basic();
        test_slow_and_zero();
        test_clamp();
        test_back_to_back();
        test_reset_mid_div();
        test_wide();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/freq_generator.md
Name: freq_generator

Overview:
- Programmable square-wave source; the transmit-side counterpart of the frequency counter.
- Accepts a target frequency in Hz and computes the half-period in clock cycles with a multi-cycle restoring divider.
- Drives a 50%-duty square wave on signalOut.
- Used as an on-board stimulus source that loops back into the counter's signalIn for self-test.

Parameters:
- CLK_HZ, 50000000, frequency of clock in Hz; the divider's dividend constant.
- WIDTH, 32, width of freq_in, the divider and the half-period counter.

Ports:
- clock  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- freq_in  input  WIDTH  requested output frequency in Hz; sampled only when load is accepted.
- load  input  1  one-cycle request strobe; accepted only when busy=0.
- signalOut  output  1  generated square wave.
- busy  output  1  divider in progress.
- half_period  output  WIDTH  active half-period in clock cycles.
- clamped  output  1  last accepted request exceeded CLK_HZ/2.

Behaviour:
- Reset (async, active-high) values: signalOut=0, busy=0, half_period=0, clamped=0, state=IDLE, toggle counter=0. Reset mid-divide aborts the division; no partial result is ever applied.
- States:
  - IDLE: no tone; signalOut held 0.
  - DIV: iterative division running.
  - RUN: tone active.
- Load acceptance:
  - Valid in IDLE or RUN when busy=0. On the accepting edge, latch f=freq_in, go to DIV, busy=1 from the next cycle.
  - load while busy=1 is ignored; no queuing.
- DIV:
  - Restoring division of CLK_HZ by 2*f, using a (WIDTH+1)-bit divisor so no bits overflow.
  - One quotient bit per cycle, exactly WIDTH cycles.
  - busy stays high for exactly WIDTH cycles. On the edge where busy falls, the result q is committed.
- Commit rules:
  - f==0: half_period=0, clamped=0. Go to IDLE and force signalOut=0 on the commit edge.
  - f!=0 and q==0 (2*f > CLK_HZ): half_period=1, clamped=1, go to RUN.
  - Otherwise: half_period=q, clamped=0, go to RUN.
- Toggle counter in RUN:
  - Counts down. When it reaches 0, signalOut inverts and the counter reloads with half_period-1.
  - Output period is therefore 2*half_period cycles.
- Entering RUN from IDLE: the counter loads half_period-1 on the commit edge. The first rising edge of signalOut comes half_period cycles after commit.
- Re-program while in RUN:
  - During DIV, the old tone keeps toggling with the old half-period; the toggle counter keeps running.
  - The committed value takes effect at the next reload. The current half-cycle is never truncated, so there is no glitch.
- Simultaneous commit and toggle (counter hits 0 on the commit edge): the toggle happens and the reload uses the new half_period.
- Quotient width is WIDTH bits. CLK_HZ must fit in WIDTH bits, so q never overflows.

Test Plan:
- CLK_HZ=1000. reset, load freq_in=100 → busy high 32 cycles, then half_period=5, clamped=0. signalOut first rises 5 cycles after commit, then period 10 cycles at 50% duty over 10 periods.
- CLK_HZ=1000. load freq_in=3 → half_period=166 (1000/6 floored), period 332 cycles. Then load freq_in=0 → after 32 busy cycles, signalOut=0 and stays 0, half_period=0.
- CLK_HZ=1000. load freq_in=1000 (2f=2000>1000) → half_period=1, clamped=1, signalOut toggles every cycle. Then load freq_in=500 → q=1, half_period=1, clamped=0.
- Running at freq_in=100. Pulse load with freq_in=50, and again with freq_in=10 while busy=1 → second load ignored. half_period becomes 10. The old 5-cycle half-period completes, then 10-cycle halves follow with no short pulse.
- Assert reset 10 cycles into DIV → busy, signalOut, half_period and clamped go to 0 immediately, without waiting for a clock edge. After release, no commit occurs and state stays IDLE.
- freq_in=0xFFFFFFFF with CLK_HZ=50000000 → divisor needs 33 bits with no overflow. q=0, so half_period=1 and clamped=1.
